frame_read_arbiter: RTL

Shares the single read port of the binarized frame BRAM between two requesters: port 0 is the finder-pattern cross/center scanner and port 1 is the module-grid sampler of the decoder. Each cycle it grants at most one request round-robin and drives the BRAM address. It tracks the fixed BRAM read latency with a tag pipeline, so every response returns only to the requester that issued it, in order. It sits between the frame buffer and the QR analysis pipeline and replaces the direct address hookup each consumer would otherwise need.

---
 rtl/frame_read_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/frame_read_arbiter.sv
// Round-robin arbiter sharing the binarized frame BRAM read port between the finder scanner
// (port 0) and the module-grid sampler (port 1), with a latency-matched response tag pipeline.
module frame_read_arbiter #(
   parameter int unsigned WIDTH      = 480,
   parameter int unsigned HEIGHT     = 480,
   parameter int unsigned ADDR_WIDTH = 20,
   parameter int unsigned LATENCY    = 2
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       pause_in,
   input  logic [1:0]                 req_valid,
   input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
   output logic [1:0]                 req_ready,
   output logic [1:0]                 rsp_valid,
   output logic                       rsp_data,
   output logic                       rsp_err,
   output logic                       bram_en,
   output logic [ADDR_WIDTH-1:0]      bram_addr,
   input  logic                       bram_dout,
   output logic [1:0][15:0]           grant_count
);

   localparam logic [ADDR_WIDTH-1:0] NUM_PIXELS = ADDR_WIDTH'(WIDTH * HEIGHT);

   logic                  last_grant_q;
   logic [1:0]            grant;
   logic                  accept;
   logic                  acc_port;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic                  acc_err;

   logic                  bram_en_q;
   logic [ADDR_WIDTH-1:0] bram_addr_q;
   logic [LATENCY:0]      tag_valid_q;
   logic [LATENCY:0]      tag_port_q;
   logic [LATENCY:0]      tag_err_q;
   logic [1:0][15:0]      count_q;

   // On a tie the port that did not win last time gets the grant.
   always_comb begin
      grant = 2'b00;
      if (!pause_in) begin
         case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   assign accept   = |grant;
   assign acc_port = grant[1];
   assign acc_addr = req_addr[acc_port];
   assign acc_err  = (acc_addr >= NUM_PIXELS);

   // Flops never see rst_in as data; the gate only keeps ready low while reset is held.
   assign req_ready = grant & {2{rst_in}};

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         last_grant_q <= 1'b1;
         bram_en_q    <= 1'b0;
         bram_addr_q  <= '0;
         tag_valid_q  <= '0;
         tag_port_q   <= '0;
         tag_err_q    <= '0;
         count_q      <= '0;
      end else begin
         if (accept) begin
            last_grant_q <= acc_port;
         end
         bram_en_q <= accept && !acc_err;
         if (accept && !acc_err) begin
            bram_addr_q <= acc_addr;
         end
         // Stage LATENCY lines up with the cycle the BRAM data for this read is valid.
         tag_valid_q <= {tag_valid_q[LATENCY-1:0], accept};
         tag_port_q  <= {tag_port_q[LATENCY-1:0], accept && acc_port};
         tag_err_q   <= {tag_err_q[LATENCY-1:0], accept && acc_err};
         for (int i = 0; i < 2; i++) begin
            if (grant[i] && (count_q[i] != 16'hFFFF)) begin
               count_q[i] <= count_q[i] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      rsp_valid = 2'b00;
      if (tag_valid_q[LATENCY]) begin
         rsp_valid = tag_port_q[LATENCY] ? 2'b10 : 2'b01;
      end
   end

   assign rsp_err     = tag_valid_q[LATENCY] && tag_err_q[LATENCY];
   assign rsp_data    = tag_valid_q[LATENCY] && !tag_err_q[LATENCY] && bram_dout;
   assign bram_en     = bram_en_q;
   assign bram_addr   = bram_addr_q;
   assign grant_count = count_q;

endmodule
